cortex_m0_register_file: RTL and testbench
==========================================

CORTEX_M0_REGISTER_FILE -- requirements
Module: cortex_m0_register_file

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter SP_RESET, default 32'h0000_0000, SP value after reset (bits [1:0] ignored, forced 0).
REQ-003 Parameter PC_RESET, default 32'h0000_0000, PC value after reset (bit 0 ignored, forced 0).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 read_register_1  input  4  index for read port 1.
REQ-008 read_register_2  input  4  index for read port 2.
REQ-009 write_register  input  4  index for write port.
REQ-010 write_enable  input  1  write strobe, active-high.
REQ-011 write_data  input  DATA_W  write value.
REQ-012 read_data_1  output  DATA_W  contents of register read_register_1.
REQ-013 read_data_2  output  DATA_W  contents of register read_register_2.
REQ-014 R0..R12  output  DATA_W each  direct views of registers 0..12.
REQ-015 SP  output  DATA_W  direct view of register 13.
REQ-016 PC  output  DATA_W  direct view of register 15.

Function
REQ-017 Storage: 16 registers indexed 0..15; 0-12 general purpose, 13 = SP, 14 = LR (no dedicated view port), 15 = PC.
REQ-018 Write: on rising clk with write_enable=1, register[write_register] <= write_data; write_enable=0 leaves all registers unchanged.
REQ-019 Write latency: the new value is visible on read ports and view ports immediately after the writing edge, never before.
REQ-020 SP write stores {write_data[DATA_W-1:2], 2'b00} (word alignment).
REQ-021 PC write stores {write_data[DATA_W-1:1], 1'b0} (halfword alignment).
REQ-022 Writes to 0-12 and 14 store write_data unmodified.
REQ-023 Read ports are purely combinational from the stored state, with no write-through bypass: reading the index being written in the same cycle returns the old value until the edge.
REQ-024 The two read ports are independent and may address the same register, including the write target.
REQ-025 View ports R0..R12, SP, PC are continuous combinational copies of the stored registers.
REQ-026 There is no X propagation: every 4-bit index is valid, and no illegal index exists.

Reset
REQ-027 While rst_n=0 (asynchronous assert), registers 0-12 and LR = 0, SP = SP_RESET with bits [1:0] cleared, PC = PC_RESET with bit 0 cleared, regardless of clk.
REQ-028 Writes are ignored while rst_n=0; the first write takes effect at the first rising clk after rst_n deasserts.
REQ-029 Reset mid-operation discards any pending write in that cycle.

Structure
REQ-030 Shared package cortex_m0_pkg holds DATA_W default, REG_SP=13, REG_LR=14, REG_PC=15 and the 4-bit register-index typedef.
REQ-031 One sub-module, cortex_m0_rf_read_port (16:1 DATA_W mux), is instantiated twice for the read ports; storage and write logic stay in the top module.

Verification
REQ-032 Reset, then read_register_1=1, read_register_2=2 -> read_data_1=read_data_2=0, R1=R2=R3=0.
REQ-033 write_register=3, write_enable=1, write_data=32'hABCDEF01, one edge -> R3=32'hABCDEF01, R1=R2=0; read_register_1=3 -> read_data_1=32'hABCDEF01.
REQ-034 write_register=13, data=32'h2000_0FFF -> SP=32'h2000_0FFC; write_register=15, data=32'h0000_0101 -> PC=32'h0000_0100.
REQ-035 write_enable=0, write_register=5, data=32'h1234_5678, several edges -> R5 stays 0; same-cycle read of R5 with write_enable=1 shows old value before the edge and new value after it.
REQ-036 Write R7=32'hDEAD_BEEF, assert rst_n=0 between clock edges -> R7=0 and SP/PC=reset values immediately, without waiting for clk.
REQ-037 Write LR (14)=32'h0000_00A5 -> no view port changes; read_register_2=14 -> read_data_2=32'h0000_00A5.

Source files
------------

// File: rtl/cortex_m0_pkg.sv
// Shared definitions for the Cortex-M0 style register file: widths,
// architectural register indices and the register-index type.
package cortex_m0_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int NUM_REGS       = 16;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t REG_SP = 4'd13;
    localparam reg_idx_t REG_LR = 4'd14;
    localparam reg_idx_t REG_PC = 4'd15;

endpackage : cortex_m0_pkg

// File: rtl/cortex_m0_rf_read_port.sv
// One combinational read port of the register file: a 16:1 mux over the
// stored register image, selected by a 4-bit register index.
module cortex_m0_rf_read_port
    import cortex_m0_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  reg_idx_t                        sel,
    output logic [DATA_W-1:0]               data
);

    // Every 4-bit index addresses a real register, so no out-of-range path exists.
    always_comb begin
        data = regs[sel];
    end

endmodule : cortex_m0_rf_read_port

// File: rtl/cortex_m0_register_file.sv
// Cortex-M0 style 16-entry register file: one write port with SP/PC
// alignment, two combinational read ports and direct architectural views.
module cortex_m0_register_file
    import cortex_m0_pkg::*;
#(
    parameter int                 DATA_W   = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0]  SP_RESET = {DATA_W{1'b0}},
    parameter logic [DATA_W-1:0]  PC_RESET = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  reg_idx_t          read_register_1,
    input  reg_idx_t          read_register_2,
    input  reg_idx_t          write_register,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic [DATA_W-1:0] R0,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [DATA_W-1:0] R3,
    output logic [DATA_W-1:0] R4,
    output logic [DATA_W-1:0] R5,
    output logic [DATA_W-1:0] R6,
    output logic [DATA_W-1:0] R7,
    output logic [DATA_W-1:0] R8,
    output logic [DATA_W-1:0] R9,
    output logic [DATA_W-1:0] R10,
    output logic [DATA_W-1:0] R11,
    output logic [DATA_W-1:0] R12,
    output logic [DATA_W-1:0] SP,
    output logic [DATA_W-1:0] PC
);

    // Reset images carry the same alignment that a software write would get.
    localparam logic [DATA_W-1:0] SP_RESET_ALIGNED = {SP_RESET[DATA_W-1:2], 2'b00};
    localparam logic [DATA_W-1:0] PC_RESET_ALIGNED = {PC_RESET[DATA_W-1:1], 1'b0};

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_r;
    logic [DATA_W-1:0]               wr_value_s;

    // Value actually stored: SP is word aligned, PC halfword aligned, others raw.
    always_comb begin
        wr_value_s = write_data;
        case (write_register)
            REG_SP:  wr_value_s = {write_data[DATA_W-1:2], 2'b00};
            REG_PC:  wr_value_s = {write_data[DATA_W-1:1], 1'b0};
            default: wr_value_s = write_data;
        endcase
    end

    // Register storage; reset wins over any write presented in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_r         <= '0;
            regs_r[REG_SP] <= SP_RESET_ALIGNED;
            regs_r[REG_PC] <= PC_RESET_ALIGNED;
        end else if (write_enable) begin
            regs_r[write_register] <= wr_value_s;
        end
    end

    cortex_m0_rf_read_port #(
        .DATA_W (DATA_W)
    ) u_read_port_1 (
        .regs (regs_r),
        .sel  (read_register_1),
        .data (read_data_1)
    );

    cortex_m0_rf_read_port #(
        .DATA_W (DATA_W)
    ) u_read_port_2 (
        .regs (regs_r),
        .sel  (read_register_2),
        .data (read_data_2)
    );

    // LR (index 14) deliberately has no view port; it is reachable via the read ports only.
    assign R0  = regs_r[0];
    assign R1  = regs_r[1];
    assign R2  = regs_r[2];
    assign R3  = regs_r[3];
    assign R4  = regs_r[4];
    assign R5  = regs_r[5];
    assign R6  = regs_r[6];
    assign R7  = regs_r[7];
    assign R8  = regs_r[8];
    assign R9  = regs_r[9];
    assign R10 = regs_r[10];
    assign R11 = regs_r[11];
    assign R12 = regs_r[12];
    assign SP  = regs_r[REG_SP];
    assign PC  = regs_r[REG_PC];

endmodule : cortex_m0_register_file

// File: tb/tb_cortex_m0_register_file.sv
// Directed scoreboard bench for cortex_m0_register_file: expectations are queued
// from a bench-side register model and popped against the DUT outputs.
module tb_cortex_m0_register_file;

    localparam logic [31:0] SP_RST = 32'h2000_0403;
    localparam logic [31:0] PC_RST = 32'h0000_0081;
    localparam int SEL_RD1 = 16;
    localparam int SEL_RD2 = 17;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rr1, rr2, wr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd1, rd2, sp, pc;
    logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12;

    typedef struct {
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model[16];

    always #5 clk = ~clk;

    cortex_m0_register_file #(
        .DATA_W   (32),
        .SP_RESET (SP_RST),
        .PC_RESET (PC_RST)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .read_register_1 (rr1),
        .read_register_2 (rr2),
        .write_register  (wr),
        .write_enable    (we),
        .write_data      (wd),
        .read_data_1     (rd1),
        .read_data_2     (rd2),
        .R0 (r0), .R1 (r1), .R2 (r2), .R3 (r3), .R4 (r4), .R5 (r5), .R6 (r6),
        .R7 (r7), .R8 (r8), .R9 (r9), .R10 (r10), .R11 (r11), .R12 (r12),
        .SP (sp),
        .PC (pc)
    );

    function automatic logic [31:0] obs(int sel);
        case (sel)
            0: return r0;   1: return r1;   2: return r2;   3: return r3;
            4: return r4;   5: return r5;   6: return r6;   7: return r7;
            8: return r8;   9: return r9;   10: return r10; 11: return r11;
            12: return r12; 13: return sp;  15: return pc;
            SEL_RD1: return rd1;
            SEL_RD2: return rd2;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    function automatic logic [31:0] stored_value(int idx, logic [31:0] d);
        if (idx == 13) return d & 32'hFFFF_FFFC;
        if (idx == 15) return d & 32'hFFFF_FFFE;
        return d;
    endfunction

    task automatic push(int sel, logic [31:0] v);
        exp_t e;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain(string tag);
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = obs(e.sel);
            checks++;
            assert (got === e.exp) else begin
                errors++;
                $error("FAIL %s sel=%0d observed=%h expected=%h", tag, e.sel, got, e.exp);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        model[13] = SP_RST & 32'hFFFF_FFFC;
        model[15] = PC_RST & 32'hFFFF_FFFE;
    endtask

    task automatic check_views(string tag);
        for (int i = 0; i < 16; i++) begin
            if (i != 14) push(i, model[i]);
        end
        drain(tag);
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic do_write(int idx, logic [31:0] d);
        wr = idx[3:0];
        wd = d;
        we = 1'b1;
        @(posedge clk);
        #1;
        model[idx] = stored_value(idx, d);
        we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        rr1 = 4'd0; rr2 = 4'd0; wr = 4'd0; we = 1'b0; wd = 32'h0;
        model_reset();

        // Reset state held across clock edges, with a write strobe that must be ignored
        repeat (2) @(negedge clk);
        we = 1'b1; wr = 4'd4; wd = 32'hFFFF_FFFF;
        @(negedge clk);
        check_views("reset_views");
        we = 1'b0;

        rst_n = 1'b1;
        rr1 = 4'd1; rr2 = 4'd2;
        #1;
        push(SEL_RD1, 32'h0);
        push(SEL_RD2, 32'h0);
        push(1, 32'h0); push(2, 32'h0); push(3, 32'h0);
        drain("post_reset_read");
        @(negedge clk);

        // Basic write of R3
        do_write(3, 32'hABCD_EF01);
        push(3, 32'hABCD_EF01); push(1, 32'h0); push(2, 32'h0);
        drain("write_r3");
        rr1 = 4'd3;
        #1;
        push(SEL_RD1, 32'hABCD_EF01);
        drain("read_r3");
        @(negedge clk);

        // SP/PC alignment
        do_write(13, 32'h2000_0FFF);
        push(13, 32'h2000_0FFC);
        drain("sp_align");
        do_write(15, 32'h0000_0101);
        push(15, 32'h0000_0100);
        drain("pc_align");

        // Disabled writes change nothing
        wr = 4'd5; wd = 32'h1234_5678; we = 1'b0;
        repeat (3) @(negedge clk);
        check_views("we_low");

        // Same-cycle read of the write target: old before the edge, new after
        rr1 = 4'd5; rr2 = 4'd5; we = 1'b1;
        #1;
        push(SEL_RD1, 32'h0); push(SEL_RD2, 32'h0); push(5, 32'h0);
        drain("no_bypass");
        @(posedge clk);
        #1;
        we = 1'b0;
        model[5] = 32'h1234_5678;
        push(SEL_RD1, 32'h1234_5678); push(SEL_RD2, 32'h1234_5678); push(5, 32'h1234_5678);
        drain("after_edge");
        @(negedge clk);

        // LR write: no view changes, visible through read port 2
        do_write(14, 32'h0000_00A5);
        check_views("lr_no_view");
        rr2 = 4'd14;
        #1;
        push(SEL_RD2, 32'h0000_00A5);
        drain("lr_read");
        @(negedge clk);

        // Random sweep of all registers through both ports
        for (int i = 0; i < 16; i++) do_write(i, $urandom);
        check_views("sweep_views");
        for (int i = 0; i < 16; i++) begin
            rr1 = i[3:0];
            rr2 = 4'(15 - i);
            #1;
            push(SEL_RD1, model[i]);
            push(SEL_RD2, model[15 - i]);
            drain("sweep_read");
        end
        @(negedge clk);

        // Asynchronous reset between edges, with a pending write that must be discarded
        do_write(7, 32'hDEAD_BEEF);
        push(7, 32'hDEAD_BEEF);
        drain("write_r7");
        wr = 4'd7; wd = 32'h5555_5555; we = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_views("async_reset");
        @(posedge clk);
        #1;
        check_views("reset_discard");
        @(negedge clk);
        rst_n = 1'b1;
        wr = 4'd7; wd = 32'h0BAD_F00D; we = 1'b1;
        #1;
        push(7, 32'h0);
        drain("first_write_pre");
        @(posedge clk);
        #1;
        we = 1'b0;
        push(7, 32'h0BAD_F00D);
        drain("first_write_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_cortex_m0_register_file
